// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the NZCV flag register, evaluates the
// instruction condition against it and gates the decoder's write/branch strobes.
module cond_logic #(
  parameter bit NONE_COND_NV = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       ShiftCarry,
  input  logic       LogicalOp,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       storedCarry,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [3:0] flags_p0;

  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = ~NONE_COND_NV;
    endcase
    return res;
  endfunction

  // Evaluate stage: condition and gated strobes from the pre-update flags
  always_comb begin
    CondEx   = eval_cond(Cond, flags_p0);
    PCSrc    = PCS  & CondEx;
    RegWrite = RegW & CondEx;
    MemWrite = MemW & CondEx;
  end

  // Flag register stage: N,Z and C,V groups update independently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_p0 <= 4'b0000;
    end else if (CondEx) begin
      if (FlagW[1]) begin
        flags_p0[3:2] <= ALUFlags[3:2];
      end
      if (FlagW[0]) begin
        flags_p0[1] <= LogicalOp ? ShiftCarry : ALUFlags[1];
        if (!LogicalOp) begin
          flags_p0[0] <= ALUFlags[0];
        end
      end
    end
  end

  assign storedCarry = flags_p0[1];
  assign Flags       = flags_p0;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: vector table, full condition sweep and
// hand-written reset and back-to-back carry sequences.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       ShiftCarry;
  logic       LogicalOp;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       storedCarry;
  logic       CondEx;
  logic [3:0] Flags;

  int total = 0;
  int bad   = 0;

  cond_logic #(.NONE_COND_NV(1'b1)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
    .ShiftCarry(ShiftCarry), .LogicalOp(LogicalOp), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .storedCarry(storedCarry),
    .CondEx(CondEx), .Flags(Flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] init;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       lop;
    logic       sc;
    logic       regw;
    logic       memw;
    logic       pcs;
    logic       e_condex;
    logic       e_rw;
    logic       e_mw;
    logic       e_pc;
    logic [3:0] e_flags;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Independent reference for the condition table
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'd0)  return z;
    if (c == 4'd1)  return !z;
    if (c == 4'd2)  return cy;
    if (c == 4'd3)  return !cy;
    if (c == 4'd4)  return n;
    if (c == 4'd5)  return !n;
    if (c == 4'd6)  return v;
    if (c == 4'd7)  return !v;
    if (c == 4'd8)  return cy && !z;
    if (c == 4'd9)  return !cy || z;
    if (c == 4'd10) return n ~^ v;
    if (c == 4'd11) return n ^ v;
    if (c == 4'd12) return !z && (n ~^ v);
    if (c == 4'd13) return z || (n ^ v);
    if (c == 4'd14) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    Cond = 4'hE; ALUFlags = 4'h0; ShiftCarry = 1'b0; LogicalOp = 1'b0;
    FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] v);
    @(negedge clk);
    idle_inputs();
    FlagW = 2'b11;
    ALUFlags = v;
    @(posedge clk);
    #1;
    FlagW = 2'b00;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    vecs[0] = '{4'b0000, 4'hE, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110};
    vecs[1] = '{4'b0110, 4'h0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0110};
    vecs[2] = '{4'b0001, 4'hE, 4'b0000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011};
    vecs[3] = '{4'b0100, 4'h1, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};
    vecs[4] = '{4'b1000, 4'hB, 4'b0100, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100};
    vecs[5] = '{4'b1001, 4'hA, 4'b0010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010};
    vecs[6] = '{4'b0010, 4'h8, 4'b1111, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[7] = '{4'b0110, 4'h8, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110};
    vecs[8] = '{4'b1111, 4'hF, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111};
    vecs[9] = '{4'b0011, 4'hE, 4'b1100, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001};

    // Reset state and mid-cycle asynchronous reset
    #12;
    check("reset_flags", Flags, 4'b0000);
    check("reset_carry", {3'b0, storedCarry}, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    set_flags(4'b1111);
    check("preset_flags", Flags, 4'b1111);
    Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1010;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_flags", Flags, 4'b0000);
    check("async_reset_carry", {3'b0, storedCarry}, 4'b0000);
    Cond = 4'h0;
    #1;
    check("reset_eq_condex", {3'b0, CondEx}, 4'b0000);
    Cond = 4'hE;
    @(posedge clk);
    #1;
    check("reset_discard", Flags, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();

    // Vector table
    for (int i = 0; i < 10; i++) begin
      set_flags(vecs[i].init);
      @(negedge clk);
      Cond = vecs[i].cond; ALUFlags = vecs[i].alu; FlagW = vecs[i].flagw;
      LogicalOp = vecs[i].lop; ShiftCarry = vecs[i].sc;
      RegW = vecs[i].regw; MemW = vecs[i].memw; PCS = vecs[i].pcs;
      #1;
      check($sformatf("v%0d_condex", i), {3'b0, CondEx}, {3'b0, vecs[i].e_condex});
      check($sformatf("v%0d_regwrite", i), {3'b0, RegWrite}, {3'b0, vecs[i].e_rw});
      check($sformatf("v%0d_memwrite", i), {3'b0, MemWrite}, {3'b0, vecs[i].e_mw});
      check($sformatf("v%0d_pcsrc", i), {3'b0, PCSrc}, {3'b0, vecs[i].e_pc});
      check($sformatf("v%0d_carry_old", i), {3'b0, storedCarry}, {3'b0, vecs[i].init[1]});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_flags", i), Flags, vecs[i].e_flags);
      check($sformatf("v%0d_carry_new", i), {3'b0, storedCarry}, {3'b0, vecs[i].e_flags[1]});
    end

    // Full condition sweep; FlagW=00 keeps flags stable across any edge
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1;
        check($sformatf("sweep_f%0d_c%0d", f, c), {3'b0, CondEx}, {3'b0, ref_cond(4'(c), 4'(f))});
      end
      check($sformatf("sweep_f%0d_hold", f), Flags, 4'(f));
    end

    // Back-to-back ADDS then ADC
    set_flags(4'b0000);
    @(negedge clk);
    Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0010; LogicalOp = 1'b0;
    #1;
    check("adds_carry_old", {3'b0, storedCarry}, 4'b0000);
    @(negedge clk);
    FlagW = 2'b00; ALUFlags = 4'b0000; RegW = 1'b1;
    #1;
    check("adc_carry_early", {3'b0, storedCarry}, 4'b0001);
    #3;
    check("adc_carry_late", {3'b0, storedCarry}, 4'b0001);
    check("adc_regwrite", {3'b0, RegWrite}, 4'b0001);
    @(posedge clk);
    #1;
    check("adc_carry_after", {3'b0, storedCarry}, 4'b0001);
    check("adc_flags_after", Flags, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
